// File: rtl/seq_pkg.sv
// Shared definitions for the 1011 sequence transmitter and detector side:
// preamble pattern and transmitter FSM state encoding.
package seq_pkg;

  localparam logic [3:0] SEQ_PREAMBLE = 4'b1011;
  localparam int         SEQ_PRE_LEN  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    DATA = 2'd2,
    GAP  = 2'd3
  } seq_tx_state_t;

  function automatic int seq_max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: 1011 preamble, MSB-first payload, then GAP_BITS
// idle zeros, one bit per clock on a registered ser_out.
module seq_frame_tx
  import seq_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int GAP_BITS = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              ser_out,
  output logic              frame_active,
  output logic              frame_done
);

  localparam int CNT_W = $clog2(seq_max3(SEQ_PRE_LEN, DATA_W, GAP_BITS) + 1);
  localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(SEQ_PRE_LEN - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

  seq_tx_state_t     state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              ser_q, ser_d;
  logic              active_q, active_d;
  logic              done_q, done_d;
  logic              accept;

  // State/counter pair (s, c) describes the bit on ser_out; this says whether
  // it is the final bit of the frame.
  function automatic logic is_last(input seq_tx_state_t s, input logic [CNT_W-1:0] c);
    if (GAP_BITS == 0) return (s == DATA) && (c == DATA_LAST);
    return (s == GAP) && (c == GAP_LAST);
  endfunction

  assign data_ready   = (state_q == IDLE) || is_last(state_q, cnt_q);
  assign accept       = data_valid && data_ready;
  assign ser_out      = ser_q;
  assign frame_active = active_q;
  assign frame_done   = done_q;

  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    state_d = state_q;
    cnt_d   = '0;
    shreg_d = shreg_q;
    ser_d   = 1'b0;

    case (state_q)
      IDLE: state_d = IDLE;
      PRE: begin
        if (cnt_q == PRE_LAST) state_d = DATA;
        else                   cnt_d   = cnt_q + CNT_W'(1);
      end
      DATA: begin
        if (cnt_q == DATA_LAST) state_d = (GAP_BITS == 0) ? IDLE : GAP;
        else                    cnt_d   = cnt_q + CNT_W'(1);
      end
      GAP: begin
        if (cnt_q == GAP_LAST) state_d = IDLE;
        else                   cnt_d   = cnt_q + CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase

    // Accept is only possible in IDLE or the last frame cycle, so it simply
    // overrides the natural end-of-frame transition.
    if (accept) begin
      state_d = PRE;
      cnt_d   = '0;
      shreg_d = data_in;
    end

    case (state_d)
      PRE:  ser_d = SEQ_PREAMBLE[2'(SEQ_PRE_LEN - 1) - cnt_d[1:0]];
      DATA: begin
        ser_d   = shreg_q[DATA_W-1];
        shreg_d = shreg_q << 1;
      end
      default: ser_d = 1'b0;
    endcase

    active_d = (state_d != IDLE);
    done_d   = is_last(state_d, cnt_d);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shreg_q  <= '0;
      ser_q    <= 1'b0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shreg_q  <= shreg_d;
      ser_q    <= ser_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_seq_frame_tx.sv
// Scoreboard bench for seq_frame_tx: an 8-bit/2-gap instance and a
// 4-bit/zero-gap instance, checked bit by bit against expected frames.
module tb_seq_frame_tx;

  typedef struct packed {
    logic bit_v;
    logic last;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic [7:0] din_a;
  logic       val_a, rdy_a, ser_a, act_a, done_a;
  logic [3:0] din_b;
  logic       val_b, rdy_b, ser_b, act_b, done_b;

  seq_frame_tx #(.DATA_W(8), .GAP_BITS(2)) u_a (
    .clk(clk), .reset_n(reset_n), .data_in(din_a), .data_valid(val_a),
    .data_ready(rdy_a), .ser_out(ser_a), .frame_active(act_a), .frame_done(done_a)
  );

  seq_frame_tx #(.DATA_W(4), .GAP_BITS(0)) u_b (
    .clk(clk), .reset_n(reset_n), .data_in(din_b), .data_valid(val_b),
    .data_ready(rdy_b), .ser_out(ser_b), .frame_active(act_b), .frame_done(done_b)
  );

  exp_t        q_a[$], q_b[$];
  logic        cur_act_a = 1'b0, cur_last_a = 1'b0;
  logic        cur_act_b = 1'b0, cur_last_b = 1'b0;
  logic [31:0] cap_a = '0, cap_b = '0;
  int          cyc = 0, acc_a = 0, acc_b = 0;
  int          acc_cyc_a[$], acc_cyc_b[$];
  int          n_assert = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame_a(input logic [7:0] w);
    logic [3:0] pre;
    pre = 4'b1011;
    for (int i = 3; i >= 0; i--) q_a.push_back('{bit_v: pre[i], last: 1'b0});
    for (int i = 7; i >= 0; i--) q_a.push_back('{bit_v: w[i], last: 1'b0});
    q_a.push_back('{bit_v: 1'b0, last: 1'b0});
    q_a.push_back('{bit_v: 1'b0, last: 1'b1});
  endtask

  task automatic push_frame_b(input logic [3:0] w);
    logic [3:0] pre;
    pre = 4'b1011;
    for (int i = 3; i >= 0; i--) q_b.push_back('{bit_v: pre[i], last: 1'b0});
    for (int i = 3; i >= 0; i--) q_b.push_back('{bit_v: w[i], last: (i == 0)});
  endtask

  // Accept model: ready when idle or showing the last bit of a frame.
  initial begin : accept_model
    forever begin
      @(posedge clk);
      cyc++;
      if (reset_n === 1'b1) begin
        if (val_a && (!cur_act_a || cur_last_a)) begin
          push_frame_a(din_a);
          acc_a++;
          acc_cyc_a.push_back(cyc);
        end
        if (val_b && (!cur_act_b || cur_last_b)) begin
          push_frame_b(din_b);
          acc_b++;
          acc_cyc_b.push_back(cyc);
        end
      end
    end
  end

  initial begin : monitor
    exp_t ea, eb;
    forever begin
      @(negedge clk);
      if (q_a.size() > 0) begin
        ea = q_a.pop_front();
        cur_act_a = 1'b1;
        cur_last_a = ea.last;
        cap_a = {cap_a[30:0], ser_a};
      end else begin
        ea = '0;
        cur_act_a = 1'b0;
        cur_last_a = 1'b0;
      end
      check("a_ser", 32'(ser_a), 32'(ea.bit_v));
      check("a_active", 32'(act_a), 32'(cur_act_a));
      check("a_done", 32'(done_a), 32'(ea.last));
      check("a_ready", 32'(rdy_a), 32'(!cur_act_a || cur_last_a));

      if (q_b.size() > 0) begin
        eb = q_b.pop_front();
        cur_act_b = 1'b1;
        cur_last_b = eb.last;
        cap_b = {cap_b[30:0], ser_b};
      end else begin
        eb = '0;
        cur_act_b = 1'b0;
        cur_last_b = 1'b0;
      end
      check("b_ser", 32'(ser_b), 32'(eb.bit_v));
      check("b_active", 32'(act_b), 32'(cur_act_b));
      check("b_done", 32'(done_b), 32'(eb.last));
      check("b_ready", 32'(rdy_b), 32'(!cur_act_b || cur_last_b));
    end
  end

  task automatic send_a(input logic [7:0] w, input bit keep);
    int start;
    start = acc_a;
    din_a = w;
    val_a = 1'b1;
    for (int i = 0; i < 40 && acc_a == start; i++) begin
      @(posedge clk);
      #1;
    end
    check("a_accept_seen", 32'(acc_a != start), 32'd1);
    if (!keep) begin
      val_a = 1'b0;
      din_a = '0;
    end
  endtask

  task automatic send_b(input logic [3:0] w, input bit keep);
    int start;
    start = acc_b;
    din_b = w;
    val_b = 1'b1;
    for (int i = 0; i < 40 && acc_b == start; i++) begin
      @(posedge clk);
      #1;
    end
    check("b_accept_seen", 32'(acc_b != start), 32'd1);
    if (!keep) begin
      val_b = 1'b0;
      din_b = '0;
    end
  endtask

  task automatic flush_model();
    q_a.delete();
    q_b.delete();
    cur_act_a = 1'b0; cur_last_a = 1'b0;
    cur_act_b = 1'b0; cur_last_b = 1'b0;
  endtask

  initial begin : stimulus
    int acc_before;
    reset_n = 1'b0;
    val_a = 1'b0; din_a = '0;
    val_b = 1'b0; din_b = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // Asynchronous reset between edges while idle.
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("rst_ser", 32'(ser_a), 32'd0);
    check("rst_active", 32'(act_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_ready", 32'(rdy_a), 32'd1);
    @(negedge clk);
    #1 reset_n = 1'b1;
    repeat (4) @(negedge clk);

    // Single frame 0xA5.
    send_a(8'hA5, 1'b0);
    repeat (16) @(negedge clk);
    check("a5_stream", {18'd0, cap_a[13:0]}, 32'(14'b1011_1010_0101_00));

    // Back-to-back 0xFF then 0x00 with valid held.
    send_a(8'hFF, 1'b1);
    send_a(8'h00, 1'b0);
    repeat (20) @(negedge clk);
    check("b2b_spacing", 32'(acc_cyc_a[$] - acc_cyc_a[$-1]), 32'd14);
    check("b2b_stream", {4'd0, cap_a[27:0]}, 32'h0BFF2C00);

    // Valid pulse with new data mid-payload must be ignored.
    acc_before = acc_a;
    send_a(8'h5A, 1'b0);
    repeat (6) @(negedge clk);
    din_a = 8'hC3;
    val_a = 1'b1;
    @(negedge clk);
    val_a = 1'b0;
    din_a = '0;
    repeat (12) @(negedge clk);
    check("busy_accepts", 32'(acc_a - acc_before), 32'd1);
    check("busy_stream", {18'd0, cap_a[13:0]}, 32'(14'b1011_0101_1010_00));

    // Reset while payload bit 3 of 0x9E is on the line.
    send_a(8'h9E, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    check("mid_bit3", 32'(ser_a), 32'd1);
    #1 reset_n = 1'b0;
    flush_model();
    #1;
    check("mid_rst_ser", 32'(ser_a), 32'd0);
    check("mid_rst_active", 32'(act_a), 32'd0);
    check("mid_rst_ready", 32'(rdy_a), 32'd1);
    @(negedge clk);
    #1 reset_n = 1'b1;
    repeat (3) @(negedge clk);
    send_a(8'h3C, 1'b0);
    repeat (16) @(negedge clk);
    check("post_rst_stream", {18'd0, cap_a[13:0]}, 32'(14'b1011_0011_1100_00));

    // Zero-gap instance: 0xB then 0x6 back to back.
    send_b(4'hB, 1'b1);
    send_b(4'h6, 1'b0);
    repeat (12) @(negedge clk);
    check("zg_spacing", 32'(acc_cyc_b[$] - acc_cyc_b[$-1]), 32'd8);
    check("zg_stream", {16'd0, cap_b[15:0]}, 32'h0000BBB6);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
